minsoc_clock_divider_bank: RTL and testbench

MINSOC_CLOCK_DIVIDER_BANK -- requirements
Module: minsoc_clock_divider_bank

---
 rtl/minsoc_clock_divider_bank.sv | 116 +++++++++++
 tb/tb_minsoc_clock_divider_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minsoc_clock_divider_bank.sv
// rtl/minsoc_clock_divider_bank.sv - bank of integer clock dividers with boundary-synchronous divisor commit
// Optional CLKDIV_PHASE_ALIGN_EN adds align_i to restart all channels phase-aligned.
module minsoc_clock_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic              align_i,
`endif
    input  logic              cfg_we_i,
    input  logic [3:0]        cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic              cfg_busy_o,
    output logic              cfg_ack_o,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] clk_o
);

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic              pend_q, pend_d;
    logic [3:0]        pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0]  pend_div_q, pend_div_d;
    logic              ack_q, ack_d;

    logic [NUM_CH-1:0] last_w;
    logic [NUM_CH-1:0] commit_w;
    logic              accept_w;
    logic              align_w;

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign align_w = align_i;
`else
    assign align_w = 1'b0;
`endif

    assign accept_w = cfg_we_i && !pend_q && ({1'b0, cfg_ch_i} < 5'(NUM_CH));

    always_comb begin
        last_w   = '0;
        commit_w = '0;
        en_d     = '0;
        clk_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            div_d[c]    = div_q[c];
            last_w[c]   = (div_q[c] != '0) && (cnt_q[c] == div_q[c] - CNT_W'(1));
            en_d[c]     = last_w[c];
            clk_d[c]    = (div_q[c] > CNT_W'(1)) && (cnt_q[c] < (div_q[c] >> 1));
            cnt_d[c]    = ((div_q[c] == '0) || last_w[c]) ? '0 : cnt_q[c] + CNT_W'(1);
            // Commit only where a fresh period would start anyway, so the old period completes intact.
            commit_w[c] = pend_q && !align_w && (pend_ch_q == 4'(c))
                          && (last_w[c] || (div_q[c] == '0));
            if (align_w) begin
                cnt_d[c] = '0;
                clk_d[c] = 1'b0;
            end else if (commit_w[c]) begin
                div_d[c] = pend_div_q;
                cnt_d[c] = '0;
            end
        end
    end

    always_comb begin
        pend_d     = pend_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        ack_d      = |commit_w;
        if (|commit_w) begin
            pend_d = 1'b0;
        end
        if (accept_w) begin
            pend_d     = 1'b1;
            pend_ch_d  = cfg_ch_i;
            pend_div_d = cfg_div_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c] <= CNT_W'(DEFAULT_DIV);
                cnt_q[c] <= '0;
            end
            en_q       <= '0;
            clk_q      <= '0;
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c] <= div_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            en_q       <= en_d;
            clk_q      <= clk_d;
            pend_q     <= pend_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            ack_q      <= ack_d;
        end
    end

    assign cfg_busy_o = pend_q;
    assign cfg_ack_o  = ack_q;
    assign clk_en_o   = en_q;
    assign clk_o      = clk_q;

endmodule

// File: tb/tb_minsoc_clock_divider_bank.sv
// tb/tb_minsoc_clock_divider_bank.sv - directed vector bench for minsoc_clock_divider_bank
module tb_minsoc_clock_divider_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_busy;
    logic        cfg_ack;
    logic [3:0]  clk_en;
    logic [3:0]  clk_out;
`ifdef CLKDIV_PHASE_ALIGN_EN
    logic        align;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    minsoc_clock_divider_bank #(
        .NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(2)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
`ifdef CLKDIV_PHASE_ALIGN_EN
        .align_i    (align),
`endif
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_div_i  (cfg_div),
        .cfg_busy_o (cfg_busy),
        .cfg_ack_o  (cfg_ack),
        .clk_en_o   (clk_en),
        .clk_o      (clk_out)
    );

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [3:0]  ch;
        logic [15:0] dv;
        logic        busy;
        logic        ack;
        logic [3:0]  en;
        logic [3:0]  ck;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic r, logic we, logic [3:0] ch, logic [15:0] dv,
                                logic b, logic a, logic [3:0] en, logic [3:0] ck);
        vec_t v;
        v.rst_n = r; v.we = we; v.ch = ch; v.dv = dv;
        v.busy = b; v.ack = a; v.en = en; v.ck = ck;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [3:0] ch, input logic [15:0] dv);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_ack(input string name, input int bound);
        int seen = 0;
        for (int i = 0; i < bound && seen == 0; i++) begin
            tick();
            if (cfg_ack) seen = 1;
        end
        check(name, seen, 1);
    endtask

    // Waits for an enable pulse, then counts cycles to the next one and clk_o high cycles between.
    task automatic measure(input string name, input int ch, input int exp_per, input int exp_hi);
        int per = 0;
        int hi = 0;
        int found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (clk_en[ch]) found = 1;
        end
        if (found == 1) begin
            found = 0;
            for (int i = 0; i < 40 && found == 0; i++) begin
                tick();
                per++;
                if (clk_out[ch]) hi++;
                if (clk_en[ch]) found = 1;
            end
        end
        check({name, "_period"}, per, exp_per);
        check({name, "_high"}, hi, exp_hi);
    endtask

    initial begin
        int acks;
        int hits;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
        align = 1'b0;
`endif

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000);
        vecs[6]  = mk(1, 1, 1, 4, 1, 0, 4'b0000, 4'b1111);
        vecs[7]  = mk(1, 0, 0, 0, 0, 1, 4'b1111, 4'b0000);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 4'b1101, 4'b0010);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1101);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000);
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
        vecs[13] = mk(1, 1, 1, 5, 1, 0, 4'b1101, 4'b0010);
        vecs[14] = mk(1, 0, 0, 0, 1, 0, 4'b0000, 4'b1101);
        vecs[15] = mk(1, 0, 0, 0, 0, 1, 4'b1111, 4'b0000);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 4'b1101, 4'b0010);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 4'b0000, 4'b1101);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 4'b1101, 4'b0000);
        vecs[20] = mk(1, 0, 0, 0, 0, 0, 4'b0010, 4'b1101);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 4'b1101, 4'b0010);

        for (int i = 0; i < 22; i++) begin
            rst_n = vecs[i].rst_n; cfg_we = vecs[i].we;
            cfg_ch = vecs[i].ch; cfg_div = vecs[i].dv;
            tick();
            check($sformatf("vec%0d_busy", i), int'(cfg_busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_ack", i), int'(cfg_ack), int'(vecs[i].ack));
            check($sformatf("vec%0d_en", i), int'(clk_en), int'(vecs[i].en));
            check($sformatf("vec%0d_clk", i), int'(clk_out), int'(vecs[i].ck));
        end
        cfg_we = 1'b0;
        measure("ch1_div5", 1, 5, 2);

        // Out-of-range channel and write-while-busy are dropped.
        write_cfg(4'd4, 16'd9);
        check("oor_busy", int'(cfg_busy), 0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acks += int'(cfg_ack);
        end
        check("oor_no_ack", acks, 0);
        write_cfg(4'd2, 16'd3);
        check("first_busy", int'(cfg_busy), 1);
        write_cfg(4'd3, 16'd7);
        acks = int'(cfg_ack);
        for (int i = 0; i < 12; i++) begin
            tick();
            acks += int'(cfg_ack);
        end
        check("single_ack", acks, 1);
        check("idle_busy", int'(cfg_busy), 0);
        measure("ch3_kept", 3, 2, 1);
        measure("ch2_div3", 2, 3, 1);
        write_cfg(4'd2, 16'd3);
        wait_ack("same_value_ack", 5);

        // Channel off, then re-enabled with div=3.
        write_cfg(4'd0, 16'd0);
        wait_ack("off_ack", 4);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            hits += int'(clk_en[0]) + int'(clk_out[0]);
        end
        check("off_quiet", hits, 0);
        write_cfg(4'd0, 16'd3);
        check("reen_busy", int'(cfg_busy), 1);
        tick();
        check("reen_ack", int'(cfg_ack), 1);
        check("reen_en0", int'(clk_en[0]), 0);
        tick();
        check("reen_en1", int'(clk_en[0]), 0);
        check("reen_clk1", int'(clk_out[0]), 1);
        tick();
        check("reen_en2", int'(clk_en[0]), 0);
        check("reen_clk2", int'(clk_out[0]), 0);
        tick();
        check("reen_en3", int'(clk_en[0]), 1);

        // Reset aborts a pending write on a div=8 channel.
        write_cfg(4'd3, 16'd8);
        wait_ack("div8_ack", 4);
        write_cfg(4'd3, 16'd5);
        check("pend_busy", int'(cfg_busy), 1);
        tick();
        check("pend_busy2", int'(cfg_busy), 1);
        rst_n = 1'b0;
        tick();
        check("rst_busy", int'(cfg_busy), 0);
        check("rst_ack", int'(cfg_ack), 0);
        check("rst_en", int'(clk_en), 0);
        check("rst_clk", int'(clk_out), 0);
        rst_n = 1'b1;
        tick();
        check("rel_en0", int'(clk_en), 0);
        check("rel_clk0", int'(clk_out), 15);
        tick();
        check("rel_en1", int'(clk_en), 15);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acks += int'(cfg_ack);
        end
        check("rst_no_ack", acks, 0);
        measure("ch3_default", 3, 2, 1);

`ifdef CLKDIV_PHASE_ALIGN_EN
        write_cfg(4'd0, 16'd3);
        wait_ack("al_ack0", 5);
        write_cfg(4'd1, 16'd6);
        wait_ack("al_ack1", 5);
        for (int i = 0; i < 3; i++) tick();
        align = 1'b1;
        tick();
        align = 1'b0;
        check("align_low", int'(clk_out[1:0]), 0);
        tick();
        check("align_rise", int'(clk_out[1:0]), 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
